instr_encode_loader: RTL
========================

// Module: instr_encode_loader
// PURPOSE
//  Encoder/loader side of the reduced RV32I control path: takes field-level instructions
//  (op, rd, rs1, rs2, imm) over a valid/ready stream and encodes them into 32-bit machine
//  words for the addi/bne/lw subset the control decoder understands.
//  Writes the encoded words sequentially into instruction memory through a one-cycle write
//  port. Used by testbenches and the boot path to build programs without hand-assembled hex.
// PARAMETERS
//  ADDR_WIDTH  8  word-address width of instruction memory; capacity = 2**ADDR_WIDTH words
// PORTS
//  clk       in   1             rising-edge clock
//  rst_n     in   1             synchronous reset, active-low
//  clear     in   1             synchronous restart: back to LOAD, pointer/count to 0
//  in_valid  in   1             field tuple valid
//  in_ready  out  1             loader can accept a tuple this cycle
//  in_op     in   2             00 addi, 01 bne, 10 lw, 11 illegal
//  in_rd     in   5             destination register (addi/lw)
//  in_rs1    in   5             source 1 / base register
//  in_rs2    in   5             source 2 (bne only)
//  in_imm    in   13            signed immediate (byte offset for bne)
//  in_last   in   1             tuple is final instruction of program
//  wr_en     out  1             instruction-memory write strobe
//  wr_addr   out  ADDR_WIDTH    word address of write
//  wr_data   out  32            encoded instruction word
//  count     out  ADDR_WIDTH+1  number of words written since reset/clear
//  done      out  1             program complete (sticky)
//  err       out  1             encode error (sticky)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): state LOAD, in_ready=1, wr_en=0, wr_addr=0,
//    wr_data=0, count=0, done=0, err=0. Reset overrides clear; clear overrides all else.
//  - States: LOAD (in_ready=1), WRITE (in_ready=0, wr_en=1), DONE (done=1),
//    ERROR (err=1). in_ready is 0 in every state except LOAD.
//  - LOAD: on in_valid&in_ready, legal tuple -> register word, latch in_last, go WRITE.
//    Illegal tuple -> ERROR with no write.
//  - WRITE (exactly 1 cycle): wr_en=1, wr_addr=pointer, wr_data=word; pointer+1, count+1.
//    Next state is DONE if latched last or pointer was 2**ADDR_WIDTH-1, else LOAD.
//  - Latency: accept at edge N -> wr_en high in cycle N+1. Throughput 1 word / 2 cycles.
//  - Full: after the 2**ADDR_WIDTH-th write, go DONE and set count=2**ADDR_WIDTH.
//    The pointer is never wrapped and a full memory is never overwritten.
//  - DONE and ERROR are sticky until rst_n or clear; tuples are ignored (in_ready=0).
//  - Encodings (imm = in_imm):
//      addi: imm[11:0], rs1, 3'b000, rd, 7'b0010011
//      lw:   imm[11:0], rs1, 3'b010, rd, 7'b0000011
//      bne:  imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011
//  - Legality:
//      in_op=11 is illegal.
//      addi/lw require imm[12]==imm[11] (fits signed 12 bits).
//      bne requires imm[0]==0.
//      Unused fields (rs2 for addi/lw, rd for bne) are ignored, never checked.
//  - clear during WRITE: the write in that cycle is suppressed (wr_en=0).
//    Next cycle is LOAD with count=0.
//  - wr_addr/wr_data hold their last values when wr_en=0.
// TESTING
//  1 addi rd=1 rs1=0 imm=255 -> cycle after accept: wr_en=1, addr 0, data 0x0FF00093, count=1
//  2 lw rd=2 rs1=1 imm=4, then bne rs1=1 rs2=0 imm=-4 in_last=1
//      -> 0x0040A103 @0, then 0xFE009EE3 @1; done=1, count=2, in_ready=0
//  3 in_op=11, or addi imm=13'h0800, or bne imm=3 -> err=1, no wr_en, in_ready stays 0
//  4 ADDR_WIDTH=2, stream 5 addi with in_valid held high
//      -> 4 writes at addr 0..3, done=1, count=4, 5th tuple never accepted
//  5 clear asserted in WRITE cycle -> no wr_en; next cycle in_ready=1, count=0, next write @0
//  6 rst_n=0 mid-program (after 3 writes) -> next cycle all outputs at reset values, count=0

Source files
------------

// File: rtl/instr_encode_loader.sv
// Field-level instruction encoder and sequential instruction-memory loader.
// Encodes addi/bne/lw tuples into RV32I words and writes them one per two cycles.
module instr_encode_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [12:0]           in_imm,
   input  logic                  in_last,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {
      StLoad  = 2'd0,
      StWrite = 2'd1,
      StDone  = 2'd2,
      StError = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           data_q, data_d;
   logic                  last_q, last_d;

   logic [31:0]           enc_word;
   logic                  enc_legal;

   // Encode the incoming tuple and judge its legality.
   always_comb begin
      enc_word  = '0;
      enc_legal = 1'b0;
      unique case (in_op)
         2'b00: begin
            enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            enc_legal = (in_imm[12] == in_imm[11]);
         end
         2'b01: begin
            enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                         in_imm[4:1], in_imm[11], 7'b1100011};
            enc_legal = ~in_imm[0];
         end
         2'b10: begin
            enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            enc_legal = (in_imm[12] == in_imm[11]);
         end
         default: begin
            enc_word  = '0;
            enc_legal = 1'b0;
         end
      endcase
   end

   // Next-state logic and handshake/strobe outputs.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      addr_d   = addr_q;
      data_d   = data_q;
      last_d   = last_q;
      in_ready = 1'b0;
      wr_en    = 1'b0;
      if (clear) begin
         // Restart wins over everything; a pending write is dropped.
         state_d = StLoad;
         count_d = '0;
      end else begin
         unique case (state_q)
            StLoad: begin
               in_ready = 1'b1;
               if (in_valid) begin
                  if (enc_legal) begin
                     state_d = StWrite;
                     data_d  = enc_word;
                     addr_d  = count_q[ADDR_WIDTH-1:0];
                     last_d  = in_last;
                     // count leads by one so it already reflects the word during its write
                     count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                  end else begin
                     state_d = StError;
                  end
               end
            end
            StWrite: begin
               wr_en = 1'b1;
               // Stop at the last tuple or when the top address was just written.
               if (last_q || (addr_q == {ADDR_WIDTH{1'b1}})) begin
                  state_d = StDone;
               end else begin
                  state_d = StLoad;
               end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StError;
         endcase
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StLoad;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign wr_addr = addr_q;
   assign wr_data = data_q;
   assign count   = count_q;
   assign done    = (state_q == StDone);
   assign err     = (state_q == StError);

endmodule
